// File: rtl/swan64_pkg.sv
// Shared SWAN64 constants and key-schedule controller state encoding.
package swan64_pkg;

    localparam int unsigned BLOCK_SIZE = 64;
    localparam int unsigned SIDE_SIZE  = 32;
    localparam int unsigned KEY_SIZE   = 256;
    localparam int unsigned PD         = 24;
    localparam logic [31:0] DELTA0     = 32'h9e37_79b9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/swan64_ks_step256.sv
// Combinational SWAN64 key-schedule step: rotate key right by PD, advance delta, fold into low word.
module swan64_ks_step256
    import swan64_pkg::*;
#(
    parameter int unsigned STEP_PD     = swan64_pkg::PD,
    parameter logic [31:0] STEP_DELTA0 = swan64_pkg::DELTA0
) (
    input  logic [0:255] k,
    input  logic [31:0]  d,
    output logic [0:255] k_next,
    output logic [31:0]  d_next,
    output logic [0:31]  s
);

    logic [0:255] rot_s;

    // Bit 0 is the MSB, so moving the tail slice to the front is a right rotation.
    assign rot_s  = {k[256-STEP_PD:255], k[0:255-STEP_PD]};
    assign d_next = d + STEP_DELTA0;
    assign s      = rot_s[224:255] + d_next;
    assign k_next = {rot_s[0:223], s};

endmodule

// File: rtl/swan64_key_sched_ctrl.sv
// SWAN64 key-schedule sequencer: loads a 256-bit master key and streams one subkey per accepted beat.
module swan64_key_sched_ctrl
    import swan64_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned RW     = 8,
    parameter int unsigned PD     = swan64_pkg::PD,
    parameter logic [31:0] DELTA0 = swan64_pkg::DELTA0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [0:255]  key_in,
    input  logic          abort,
    output logic          sk_valid,
    input  logic          sk_ready,
    output logic [0:31]   sk,
    output logic [RW-1:0] sk_round,
    output logic          sk_last,
    output logic          busy
);

    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

    state_t        state_r, state_n;
    logic [0:255]  key_r, key_n;
    logic [31:0]   delta_r, delta_n;
    logic [0:31]   sk_r, sk_n;
    logic [RW-1:0] round_r, round_n;
    logic          sk_valid_r, sk_last_r, busy_r;

    logic [0:255]  step_k_s;
    logic [31:0]   step_d_s;
    logic [0:31]   step_s_s;

    swan64_ks_step256 #(
        .STEP_PD     (PD),
        .STEP_DELTA0 (DELTA0)
    ) u_step (
        .k      (key_r),
        .d      (delta_r),
        .k_next (step_k_s),
        .d_next (step_d_s),
        .s      (step_s_s)
    );

    // Next-state and datapath update; abort overrides any handshake in flight.
    always_comb begin
        state_n = state_r;
        key_n   = key_r;
        delta_n = delta_r;
        sk_n    = sk_r;
        round_n = round_r;
        if (abort) begin
            state_n = IDLE;
            key_n   = {256{1'b0}};
            delta_n = 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_valid) begin
                        key_n   = key_in;
                        delta_n = 32'h0000_0000;
                        round_n = {RW{1'b0}};
                        state_n = PRIME;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRIME: begin
                    sk_n    = step_s_s;
                    key_n   = step_k_s;
                    delta_n = step_d_s;
                    state_n = STREAM;
                end
                STREAM: begin
                    if (sk_ready && (round_r == LAST_RND)) begin
                        state_n = IDLE;
                    end else if (sk_ready) begin
                        sk_n    = step_s_s;
                        key_n   = step_k_s;
                        delta_n = step_d_s;
                        round_n = round_r + {{(RW-1){1'b0}}, 1'b1};
                    end else begin
                        state_n = STREAM;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, key material and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            key_r      <= {256{1'b0}};
            delta_r    <= 32'h0000_0000;
            sk_r       <= 32'h0000_0000;
            round_r    <= {RW{1'b0}};
            sk_valid_r <= 1'b0;
            sk_last_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            key_r      <= key_n;
            delta_r    <= delta_n;
            sk_r       <= sk_n;
            round_r    <= round_n;
            sk_valid_r <= (state_n == STREAM);
            sk_last_r  <= (state_n == STREAM) && (round_n == LAST_RND);
            busy_r     <= (state_n != IDLE);
        end
    end

    assign key_ready = (state_r == IDLE);
    assign sk_valid  = sk_valid_r;
    assign sk        = sk_r;
    assign sk_round  = round_r;
    assign sk_last   = sk_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_swan64_key_sched_ctrl.sv
// Scoreboard bench for swan64_key_sched_ctrl: stimulus queues expected subkeys, a monitor checks each beat.
module tb_swan64_key_sched_ctrl;

    localparam int          ROUNDS = 64;
    localparam int          RW     = 8;
    localparam int          PD     = 24;
    localparam logic [31:0] DELTA0 = 32'h9e3779b9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic          key_ready;
    logic [0:255]  key_in = '0;
    logic          abort = 1'b0;
    logic          sk_valid;
    logic          sk_ready = 1'b0;
    logic [0:31]   sk;
    logic [RW-1:0] sk_round;
    logic          sk_last;
    logic          busy;

    typedef struct {
        logic [31:0]   sk;
        logic [RW-1:0] rnd;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_en  = 1'b0;

    swan64_key_sched_ctrl #(.ROUNDS(ROUNDS), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .abort     (abort),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk        (sk),
        .sk_round  (sk_round),
        .sk_last   (sk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: numeric rotate-right with shifts, key held as a plain MSB-first vector.
    task automatic push_key(input logic [255:0] k, input bit hand);
        logic [255:0] kk;
        logic [255:0] r;
        logic [31:0]  d;
        logic [31:0]  s;
        exp_t         e;
        kk = k;
        d  = 32'h0;
        for (int i = 0; i < ROUNDS; i++) begin
            r  = (kk >> PD) | (kk << (256 - PD));
            d  = d + DELTA0;
            s  = r[31:0] + d;
            kk = {r[255:32], s};
            e.sk = s;
            if (hand && i == 0) e.sk = 32'h9e3779b9;
            if (hand && i == 1) e.sk = 32'h3c6ef410;
            e.rnd  = RW'(i);
            e.last = (i == ROUNDS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_key(input logic [255:0] k, input bit hand);
        int n = 0;
        while (!key_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) chk("key_ready_timeout", 32'(key_ready), 32'd1);
        key_in    = k;
        key_valid = 1'b1;
        push_key(k, hand);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            if (bp_en) sk_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        sk_ready = 1'b1;
    endtask

    task automatic wait_for(input int rnd, input bit want_last);
        int n = 0;
        while (!(sk_valid && (want_last ? sk_last : (sk_round == RW'(rnd)))) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_target", 32'(sk_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, 32'(key_ready), 32'd1);
        chk({tag, "_sk_valid"}, 32'(sk_valid), 32'd0);
        chk({tag, "_sk"}, sk, 32'd0);
        chk({tag, "_sk_round"}, 32'(sk_round), 32'd0);
        chk({tag, "_sk_last"}, 32'(sk_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every valid beat must show the queue head; pop only on a taken handshake.
    always @(negedge clk) begin
        if (rst_n && sk_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_sk_valid", 32'(sk_valid), 32'd0);
            end else begin
                checks++;
                if (sk !== sb[0].sk || sk_round !== sb[0].rnd || sk_last !== sb[0].last) begin
                    errors++;
                    $display("FAIL subkey: got sk=%h round=%0d last=%b expected sk=%h round=%0d last=%b",
                             sk, sk_round, sk_last, sb[0].sk, sb[0].rnd, sb[0].last);
                end
                if (sk_ready && !abort) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [255:0] k1, k2;
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sk_ready = 1'b1;

        // Zero key: hand-computed first subkeys and PRIME latency
        send_key(256'h0, 1'b1);
        chk("prime_busy", 32'(busy), 32'd1);
        chk("prime_key_ready", 32'(key_ready), 32'd0);
        chk("prime_sk_valid", 32'(sk_valid), 32'd0);
        @(posedge clk); #1;
        chk("first_valid", 32'(sk_valid), 32'd1);
        chk("first_round", 32'(sk_round), 32'd0);
        wait_drain(200);
        @(posedge clk); #1;
        chk("end_key_ready", 32'(key_ready), 32'd1);
        chk("end_sk_valid", 32'(sk_valid), 32'd0);

        // Random key with random backpressure
        bp_en = 1'b1;
        send_key({$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        wait_drain(2000);
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Back-to-back keys with key_valid held high
        k1 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        k2 = 256'hdeadbeefcafef00d_0badc0de12345678_a5a5a5a55a5a5a5a_ffffffff00000001;
        key_in    = k1;
        key_valid = 1'b1;
        push_key(k1, 1'b0);
        push_key(k2, 1'b0);
        @(posedge clk); #1;
        key_in = k2;
        wait_for(0, 1'b1);
        @(posedge clk); #1;
        chk("b2b_idle_ready", 32'(key_ready), 32'd1);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        chk("b2b_accept_ready", 32'(key_ready), 32'd0);
        key_valid = 1'b0;
        wait_drain(300);
        @(posedge clk); #1;

        // Abort at round 5 with a simultaneous subkey handshake
        send_key(k2, 1'b0);
        wait_for(5, 1'b0);
        chk("abort_round", 32'(sk_round), 32'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_sk_valid", 32'(sk_valid), 32'd0);
        chk("abort_key_ready", 32'(key_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        send_key(k1, 1'b0);
        wait_drain(300);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        send_key(k1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(key_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // key_valid pulsed during STREAM is ignored
        send_key(k2, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        key_in    = k1;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        wait_drain(300);
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_key_busy", 32'(busy), 32'd0);
        chk("no_queued_key_ready", 32'(key_ready), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
